// File: rtl/cardinal_nic_pkg.sv
// Shared constants and helpers for the cardinal NIC: register map, default widths
// and the status-word builder used by both status registers.
package cardinal_nic_pkg;

    localparam int NIC_DATA_W = 64;
    localparam int NIC_ADDR_W = 2;

    localparam logic [NIC_ADDR_W-1:0] NIC_ADDR_IN_BUF   = 2'b00;
    localparam logic [NIC_ADDR_W-1:0] NIC_ADDR_IN_STAT  = 2'b01;
    localparam logic [NIC_ADDR_W-1:0] NIC_ADDR_OUT_BUF  = 2'b10;
    localparam logic [NIC_ADDR_W-1:0] NIC_ADDR_OUT_STAT = 2'b11;

    // Packets number their bits MSB-first, so the last bit (the full flag) is the LSB here.
    function automatic logic [NIC_DATA_W-1:0] nic_status_word(input logic full);
        nic_status_word = {{(NIC_DATA_W-1){1'b0}}, full};
    endfunction

endpackage

// File: rtl/nic_chan_buf.sv
// One packet-wide channel buffer with a full flag; load wins over clear when both
// are requested, so an arrival into an empty buffer is never lost.
module nic_chan_buf #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] data,
    output logic              full
);

    // Packet register and full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= {DATA_W{1'b0}};
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end else begin
            full <= full;
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC top: CPU register decode and read mux, input/output channel buffers,
// and the registered router send port gated by the virtual-channel polarity.
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_W = NIC_DATA_W,
    parameter int ADDR_W = NIC_ADDR_W,
    parameter int VC_BIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicEnWr,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);

    // VC_BIT counts from the MSB.
    localparam int VC_IDX = DATA_W - 1 - VC_BIT;

    logic              cpu_rd_s;
    logic              in_load_s;
    logic              in_clear_s;
    logic              out_load_s;
    logic              drain_s;
    logic              in_full_r;
    logic              out_full_r;
    logic [DATA_W-1:0] in_buf_r;
    logic [DATA_W-1:0] out_buf_r;
    logic [DATA_W-1:0] in_stat_s;
    logic [DATA_W-1:0] out_stat_s;

    // Access decode and channel handshake conditions.
    always_comb begin
        cpu_rd_s   = nicEn & ~nicEnWr;
        in_load_s  = net_si & ~in_full_r;
        in_clear_s = 1'b0;
        out_load_s = 1'b0;
        drain_s    = out_full_r & net_ro & (out_buf_r[VC_IDX] == net_polarity);
        if (cpu_rd_s && (addr == NIC_ADDR_IN_BUF)) begin
            in_clear_s = 1'b1;
        end else begin
            in_clear_s = 1'b0;
        end
        if (nicEn && nicEnWr && (addr == NIC_ADDR_OUT_BUF) && !out_full_r) begin
            out_load_s = 1'b1;
        end else begin
            out_load_s = 1'b0;
        end
    end

    nic_chan_buf #(.DATA_W(DATA_W)) u_in_chan (
        .clk       (clk),
        .rst_n     (reset),
        .load      (in_load_s),
        .clear     (in_clear_s),
        .load_data (net_di),
        .data      (in_buf_r),
        .full      (in_full_r)
    );

    nic_chan_buf #(.DATA_W(DATA_W)) u_out_chan (
        .clk       (clk),
        .rst_n     (reset),
        .load      (out_load_s),
        .clear     (drain_s),
        .load_data (d_in),
        .data      (out_buf_r),
        .full      (out_full_r)
    );

    assign net_ri     = ~in_full_r;
    assign in_stat_s  = DATA_W'(nic_status_word(in_full_r));
    assign out_stat_s = DATA_W'(nic_status_word(out_full_r));

    // Router send port: one-cycle pulse per packet, data holds between packets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            net_so <= 1'b0;
            net_do <= {DATA_W{1'b0}};
        end else if (drain_s) begin
            net_so <= 1'b1;
            net_do <= out_buf_r;
        end else begin
            net_so <= 1'b0;
        end
    end

    // CPU read mux; the output buffer is write-only and reads back as zero.
    always_comb begin
        d_out = {DATA_W{1'b0}};
        if (cpu_rd_s) begin
            case (addr)
                NIC_ADDR_IN_BUF:   d_out = in_buf_r;
                NIC_ADDR_IN_STAT:  d_out = in_stat_s;
                NIC_ADDR_OUT_STAT: d_out = out_stat_s;
                default:           d_out = {DATA_W{1'b0}};
            endcase
        end else begin
            d_out = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Scoreboard bench for cardinal_nic: a queue-based packet model predicts reads, net_ri
// and each router send (data and cycle); a negedge monitor compares against the DUT.
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicEnWr;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicEnWr      (nicEnWr),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } send_t;

    send_t       send_q[$];
    logic [63:0] rd_q[$];
    logic        ri_q[$];
    logic [63:0] m_out_q[$];
    logic [63:0] m_in_q[$];
    logic [63:0] m_in_last;
    send_t       mon_s;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [63:0] pkt;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // One clock of stimulus; the model predicts this cycle's reads and the outcome of the next edge.
    task automatic step(input bit en, input bit wr, input logic [1:0] a, input logic [63:0] d,
                        input bit si, input logic [63:0] di, input bit ro);
        bit    out_busy;
        send_t s;
        @(posedge clk);
        #1;
        nicEn = en; nicEnWr = wr; addr = a; d_in = d;
        net_si = si; net_di = di; net_ro = ro;
        net_polarity = ~net_polarity;
        if (en && !wr) begin
            case (a)
                2'd0:    rd_q.push_back(m_in_last);
                2'd1:    rd_q.push_back({63'd0, m_in_q.size() != 0});
                2'd3:    rd_q.push_back({63'd0, m_out_q.size() != 0});
                default: rd_q.push_back(64'd0);
            endcase
        end
        ri_q.push_back(m_in_q.size() == 0);
        out_busy = (m_out_q.size() != 0);
        if (out_busy && ro && (m_out_q[0][63] == net_polarity)) begin
            s.data = m_out_q.pop_front();
            s.cyc  = cyc + 1;
            send_q.push_back(s);
        end
        if (en && wr && a == 2'd2 && !out_busy) m_out_q.push_back(d);
        if (si && m_in_q.size() == 0) begin
            m_in_q.push_back(di);
            m_in_last = di;
        end else if (en && !wr && a == 2'd0 && m_in_q.size() != 0) begin
            m_in_q.delete();
        end
    endtask

    task automatic idle(input bit ro);
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 64'd0, ro);
    endtask

    task automatic rd(input logic [1:0] a, input bit ro);
        step(1'b1, 1'b0, a, 64'd0, 1'b0, 64'd0, ro);
    endtask

    task automatic wr(input logic [63:0] d, input bit ro);
        step(1'b1, 1'b1, 2'd2, d, 1'b0, 64'd0, ro);
    endtask

    // Monitor: compares every presented output against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ri_q.size() != 0) check("net_ri", 64'(net_ri), 64'(ri_q.pop_front()));
            if (nicEn && !nicEnWr && rd_q.size() != 0) check("d_out", d_out, rd_q.pop_front());
            if (net_so) begin
                if (send_q.size() == 0) begin
                    check("net_so_unexpected", 64'(net_so), 64'd0);
                end else begin
                    mon_s = send_q.pop_front();
                    check("net_do", net_do, mon_s.data);
                    check("send_cycle", 64'(cyc), 64'(mon_s.cyc));
                end
            end
        end
    end

    initial begin
        reset = 1'b0; nicEn = 1'b0; nicEnWr = 1'b0; addr = 2'd0; d_in = 64'd0;
        net_si = 1'b0; net_di = 64'd0; net_ro = 1'b0; net_polarity = 1'b0;
        m_in_last = 64'd0;
        #2;
        check("rst_net_so", 64'(net_so), 64'd0);
        check("rst_net_do", net_do, 64'd0);
        check("rst_net_ri", 64'(net_ri), 64'd1);
        check("rst_d_out", d_out, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;

        // receive, status, read-clear
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
        rd(2'd1, 1'b0);
        rd(2'd0, 1'b0);
        rd(2'd1, 1'b0);
        rd(2'd2, 1'b0);

        // send with VC=1
        wr(64'h8000_0000_0000_00AA, 1'b1);
        rd(2'd3, 1'b1);
        rd(2'd3, 1'b1);
        rd(2'd3, 1'b1);

        // backpressure, write while full dropped
        wr(64'h8000_0000_0000_0BAD, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) wr(64'h5, 1'b0);
            else rd(2'd3, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // same-cycle drain and write
        wr(64'h1, 1'b0);
        while (net_polarity != 1'b1) idle(1'b0);
        wr(64'h7, 1'b1);
        wr(64'h7, 1'b0);
        rd(2'd3, 1'b0);
        idle(1'b1);
        idle(1'b1);
        rd(2'd3, 1'b0);

        // back-to-back receive while full
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 64'hAAAA_0000_0000_0001, 1'b0);
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 64'hBBBB_0000_0000_0002, 1'b0);
        step(1'b1, 1'b0, 2'd0, 64'd0, 1'b1, 64'hBBBB_0000_0000_0002, 1'b0);
        step(1'b0, 1'b0, 2'd0, 64'd0, 1'b1, 64'hBBBB_0000_0000_0002, 1'b0);
        rd(2'd1, 1'b0);
        rd(2'd0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), 2'($urandom),
                 {$urandom, $urandom}, ($urandom_range(0, 2) == 0),
                 {$urandom, $urandom}, 1'($urandom));
        end

        // async reset while net_so is high
        for (int i = 0; i < 4; i++) idle(1'b1);
        pkt = {net_polarity, 31'($urandom), $urandom};
        wr(pkt, 1'b1);
        idle(1'b1);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("pre_rst_net_so", 64'(net_so), 64'd1);
        check("pre_rst_net_do", net_do, pkt);
        send_q.delete();
        nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'd0;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_net_so", 64'(net_so), 64'd0);
        check("midrst_net_do", net_do, 64'd0);
        check("midrst_net_ri", 64'(net_ri), 64'd1);
        check("midrst_d_out", d_out, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_out_q.delete(); m_in_q.delete(); rd_q.delete(); ri_q.delete();
        m_in_last = 64'd0;
        mon_en = 1'b1;
        rd(2'd0, 1'b1);
        rd(2'd3, 1'b1);
        idle(1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("send_q_drained", 64'(send_q.size()), 64'd0);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        check("ri_q_drained", 64'(ri_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
